des_decrypt_iter: RTL and testbench
===================================

# des_decrypt_iter

Iterative single-DES decryption core. It accepts one 64-bit ciphertext block and a 64-bit key over a valid/ready handshake and runs the 16 Feistel rounds one per clock, using decryption-order subkeys K16..K1 generated on the fly. It returns the 64-bit plaintext over a second valid/ready handshake. It is the decrypt-side counterpart of the encrypt datapath and is the building block for the triple-DES decrypt (D-E-D) chain; the round function comes from the team's shared combinational DES f-function block, instantiated once.

## Interface
- No parameters. Block size is 64 bits, the round count is 16, and the key schedule is fixed by FIPS 46-3.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ciphertext and key on in_data/in_key are valid.
- in_ready  out  1  core is idle and can accept a block.
- in_data  in  64  ciphertext; in_data[63] is DES bit 1, in_data[0] is DES bit 64.
- in_key  in  64  DES key, same bit order; parity bits (DES bits 8, 16, …, 64) are ignored.
- out_valid  out  1  plaintext on out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  64  plaintext, same bit order as in_data.

## Operation
- States: IDLE, ROUND, DONE.
- **IDLE**
  - in_ready = 1, out_valid = 0.
  - When in_valid is high at a rising edge, the block is accepted:
    - L/R ← IP(in_data) (left and right halves).
    - C/D ← PC-1(in_key).
    - rnd ← 0.
    - Go to ROUND.
- **ROUND** (rnd = 0..15)
  - Subkey = PC-2(C, D), i.e. K(16−rnd).
  - Update: L ← R, R ← L xor f(R, subkey).
  - Then rotate C and D right by shift(16−rnd). Shift is 1 for DES round indices 1, 2, 9, 16 and 2 otherwise, so the first post-round rotation is 1, at rnd = 7 it is 1, and at rnd = 14 it is 1.
  - rnd increments by 1 each cycle.
  - At rnd = 15:
    - out_data ← FP(R16 ‖ L16), the final swap followed by the inverse initial permutation.
    - Go to DONE.
  - in_ready = 0 throughout ROUND.
- **DONE**
  - out_valid = 1 and out_data is held stable until out_ready is high at a rising edge; then go to IDLE.
  - in_ready = 0 in DONE.
- Input changes are ignored outside IDLE. in_data and in_key are captured only at the accept edge and need not be held afterwards.
- The rnd counter is 4 bits and wraps only via the state change; it never runs past 15.
- All outputs are registered.
- Reset (asynchronous, any state, including mid-round or mid-DONE):
  - Block is discarded; state ← IDLE.
  - in_ready = 1, out_valid = 0, out_data = 0, rnd = 0.
  - L, R, C, D = 0.

## Timing
- Accept at edge E0.
- Rounds execute at edges E1..E16. out_valid rises after E16, so it is visible 16 cycles after the accept edge.
- The output handshake at edge Ek returns to IDLE, and in_ready is high after Ek.
- Minimum accept-to-accept interval is 18 cycles (accept, 16 rounds, one DONE cycle with out_ready = 1).
- If out_ready is held low, the core stalls in DONE indefinitely with out_data unchanged.
- out_ready high while in IDLE or ROUND has no effect.
- in_valid high in IDLE is accepted that same edge; there is no combinational path from in_valid to in_ready.
- Critical path: f-function (E, S-boxes, P) plus the 32-bit XOR in one cycle.

## Test plan
- Known-answer vector: key 133457799BBCDFF1, in_data 85E813540F0AB405 → out_data 0123456789ABCDEF; out_valid rises exactly 16 cycles after the accept edge.
- Known-answer vector: key 0E329232EA6D0D73, in_data 0000000000000000 → 8787878787878787. Also key 0000000000000000, in_data 8CA64DE9C1B123A7 → 0000000000000000.
- Parity independence: key 12355678 9ABDDEF0 (all parity bits flipped from 133457799BBCDFF1), in_data 85E813540F0AB405 → 0123456789ABCDEF.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid: out_data stays stable, in_ready stays 0, and a toggling in_valid/in_data has no effect.
  - Raise out_ready: one transfer occurs, then in_ready = 1 on the next cycle.
- Back-to-back: two blocks presented with in_valid held high and out_ready = 1 → accepts 18 cycles apart, both outputs correct, no block dropped or duplicated.
- Reset mid-operation: assert rst_n = 0 at rnd = 8 → immediately out_valid = 0, in_ready = 1, out_data = 0. After release, a fresh block decrypts correctly with no residue from the aborted one.

Source files
------------

// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative single-DES decryption, one Feistel round per clock
// with decryption-order subkeys produced by right-rotating the C/D halves.
module des_f (
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int SB [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;

    always_comb begin
        e = '0;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        x = e ^ k;
        s = '0;
        // each S-box row is outer bits b1b6, column is inner bits b2..b5
        for (int i = 0; i < 8; i++)
            s[31-4*i -: 4] = 4'(SB[64*i + int'({x[47-6*i], x[42-6*i], x[46-6*i -: 4]})]);
        f = '0;
        for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
    end
endmodule

module des_decrypt_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] ip(input logic [63:0] x);
        for (int i = 0; i < 64; i++) ip[63-i] = x[64-IP_T[i]];
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) fp[63-i] = x[64-FP_T[i]];
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) pc1[55-i] = x[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) pc2[47-i] = x[56-PC2_T[i]];
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state, state_n;
    logic [3:0]  rnd;
    logic [31:0] l, r, fo;
    logic [27:0] c, d, c_n, d_n;
    logic [47:0] subkey;
    logic        one;
    logic        unused_parity;

    assign unused_parity = ^{in_key[56], in_key[48], in_key[40], in_key[32],
                             in_key[24], in_key[16], in_key[8], in_key[0]};

    // C16/D16 equal C0/D0, so K16 is available straight after PC-1
    assign subkey = pc2({c, d});
    assign one    = (rnd == 4'd0) || (rnd == 4'd7) || (rnd == 4'd14) || (rnd == 4'd15);
    assign c_n    = one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
    assign d_n    = one ? {d[0], d[27:1]} : {d[1:0], d[27:2]};

    des_f u_f (.r(r), .k(subkey), .f(fo));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && in_valid)        state_n = ROUND;
        if (state == ROUND && rnd == 4'd15)   state_n = DONE;
        if (state == DONE && out_ready)       state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            rnd       <= '0;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
        end else begin
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            if (state == IDLE && in_valid) begin
                {l, r} <= ip(in_data);
                {c, d} <= pc1(in_key);
                rnd    <= '0;
            end
            if (state == ROUND) begin
                l   <= r;
                r   <= l ^ fo;
                c   <= c_n;
                d   <= d_n;
                rnd <= rnd + 4'd1;
                if (rnd == 4'd15) out_data <= fp({l ^ fo, r});
            end
        end
    end
endmodule

// File: tb/tb_des_decrypt_iter.sv
// tb_des_decrypt_iter: scoreboard bench; expected plaintexts come from a forward
// DES encryption model (ciphertext = E(k, p), DUT must return p) plus known answers.
module tb_des_decrypt_iter;
    logic        clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [63:0] in_data = '0, in_key = '0, out_data;

    des_decrypt_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SB [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

    // generic 1-based DES permutation: output bit i (MSB first) = input DES bit t[i]
    function automatic logic [63:0] perm(input logic [63:0] x, input int inw, input int sel, input int n);
        logic [63:0] y;
        int t;
        y = '0;
        for (int i = 0; i < n; i++) begin
            case (sel)
                0: t = IP_T[i];
                1: t = FP_T[i];
                2: t = E_T[i];
                3: t = P_T[i];
                4: t = PC1_T[i];
                default: t = PC2_T[i];
            endcase
            y[n-1-i] = x[inw-t];
        end
        return y;
    endfunction

    function automatic logic [31:0] fmod(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        int six;
        x = 48'(perm({32'd0, r}, 32, 2, 48)) ^ k;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            six = int'(x[47-6*j -: 6]);
            s[31-4*j -: 4] = 4'(SB[64*j + ((six >> 5) & 1) * 32 + (six & 1) * 16 + ((six >> 1) & 15)]);
        end
        return 32'(perm({32'd0, s}, 32, 3, 32));
    endfunction

    function automatic logic [63:0] des_enc(input logic [63:0] k, input logic [63:0] p);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] lr;
        logic [31:0] l, r, t;
        cd = 56'(perm(k, 64, 4, 56));
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 1; i <= 16; i++) begin
            repeat ((i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i-1] = 48'(perm({8'd0, c, d}, 56, 5, 48));
        end
        lr = perm(p, 64, 0, 64);
        l = lr[63:32];
        r = lr[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ fmod(r, ks[i]);
            l = t;
        end
        return perm({r, l}, 64, 1, 64);
    endfunction

    int checks = 0, errors = 0;
    typedef struct { logic [63:0] exp; int acc; } item_t;
    item_t sb[$];
    item_t cur;
    bit seen = 0, bp_en = 0;
    logic [63:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    cur = sb.pop_front();
                    chk("latency", 64'(cyc - cur.acc), 64'd16);
                    chk("plaintext", out_data, cur.exp);
                end
                held = out_data;
            end else chk("out_hold", out_data, held);
            chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_ready) seen = 0;
        end
    end

    always @(posedge clk) if (bp_en) begin
        #1 out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [63:0] k, input logic [63:0] c, input logic [63:0] p,
                        input bit hold, output int acc);
        int n = 0;
        in_key = k;
        in_data = c;
        in_valid = 1;
        acc = -1;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else begin
            @(posedge clk);
            #1 acc = cyc;
            sb.push_back('{p, acc});
        end
        if (!hold) in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || seen) && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        if (sb.size() > 0 || seen) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k, p, k2, p2;
        int t1, t2, n;
        #2 rst_n = 0;
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, t1);
        drain();
        send(64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 0, t1);
        drain();
        send(64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000, 0, t1);
        drain();
        send(64'h123556789ABDDEF0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, t1);
        drain();

        bp_en = 1;
        for (int i = 0; i < 8; i++) begin
            k = {$urandom, $urandom};
            p = {$urandom, $urandom};
            send(k, des_enc(k, p), p, 0, t1);
        end
        drain();
        bp_en = 0;
        @(posedge clk);
        #2 out_ready = 0;

        k = {$urandom, $urandom};
        p = {$urandom, $urandom};
        send(k, des_enc(k, p), p, 0, t1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (20) begin
            @(posedge clk);
            #1 in_valid = 1'($urandom_range(0, 1));
            in_data = {$urandom, $urandom};
            in_key = {$urandom, $urandom};
        end
        chk("bp_still_valid", 64'(out_valid), 64'd1);
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);
        repeat (20) @(posedge clk);
        #1 chk("bp_no_extra_block", 64'(sb.size()), 64'd0);

        k = {$urandom, $urandom};
        p = {$urandom, $urandom};
        k2 = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        send(k, des_enc(k, p), p, 1, t1);
        send(k2, des_enc(k2, p2), p2, 0, t2);
        chk("b2b_interval", 64'(t2 - t1), 64'd18);
        drain();

        k = {$urandom, $urandom};
        p = {$urandom, $urandom};
        send(k, des_enc(k, p), p, 0, t1);
        repeat (8) @(posedge clk);
        #1 rst_n = 0;
        sb.delete();
        seen = 0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_out_data", out_data, 64'd0);
        @(posedge clk);
        #1 rst_n = 1;
        k = {$urandom, $urandom};
        p = {$urandom, $urandom};
        send(k, des_enc(k, p), p, 0, t1);
        drain();
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, t1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
